// File: rtl/fp_compare_pipe.sv
// Two-stage pipelined IEEE-754-style comparator with valid/ready on both sides.
// Stage 1 classifies operands and compares magnitudes; stage 2 resolves the relation.
module fp_compare_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [2:0]             in_op,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_result,
  output logic [EXP_W+MAN_W:0]   out_value,
  output logic                   out_unordered,
  output logic [TAG_W-1:0]       out_tag
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_GT  = 3'b000,
    OP_GE  = 3'b001,
    OP_LT  = 3'b010,
    OP_LE  = 3'b011,
    OP_EQ  = 3'b100,
    OP_NE  = 3'b101,
    OP_MIN = 3'b110,
    OP_MAX = 3'b111
  } op_e;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
  endfunction

  function automatic logic is_zero(input logic [W-1:0] x);
    return ~|x[W-2:0];
  endfunction

  logic             vld_p1, vld_p2;
  logic             adv_p1, adv_p2;
  logic [W-1:0]     a_p1, b_p1;
  logic             nan_a_p1, nan_b_p1, zero_a_p1, zero_b_p1;
  logic             mag_gt_p1, mag_eq_p1;
  op_e              op_p1;
  logic [TAG_W-1:0] tag_p1;

  assign adv_p2    = !vld_p2 || out_ready;
  assign adv_p1    = adv_p2 || !vld_p1;
  assign in_ready  = adv_p1;
  assign out_valid = vld_p2;

  // Stage 1: classification and unsigned magnitude compare
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      a_p1      <= in_a;
      b_p1      <= in_b;
      nan_a_p1  <= is_nan(in_a);
      nan_b_p1  <= is_nan(in_b);
      zero_a_p1 <= is_zero(in_a);
      zero_b_p1 <= is_zero(in_b);
      mag_gt_p1 <= in_a[W-2:0] > in_b[W-2:0];
      mag_eq_p1 <= in_a[W-2:0] == in_b[W-2:0];
      op_p1     <= op_e'(in_op);
      tag_p1    <= in_tag;
    end
  end

  logic         unord, both_zero, zero_split, sign_a, sign_b;
  logic         eq, gt, lt, sel_a;
  logic         res_c;
  logic [W-1:0] val_c;

  always_comb begin
    sign_a     = a_p1[W-1];
    sign_b     = b_p1[W-1];
    unord      = nan_a_p1 || nan_b_p1;
    both_zero  = zero_a_p1 && zero_b_p1;
    zero_split = both_zero && (sign_a != sign_b);
    eq         = !unord && (both_zero || ((sign_a == sign_b) && mag_eq_p1));
    if (unord || both_zero) gt = 1'b0;
    else if (sign_a != sign_b) gt = !sign_a;
    else if (!sign_a) gt = mag_gt_p1;
    else gt = !mag_gt_p1 && !mag_eq_p1;
    lt = !unord && !eq && !gt;

    // A NaN operand loses MIN/MAX selection; signed zeros break the tie by sign
    sel_a = 1'b1;
    if (nan_a_p1) sel_a = 1'b0;
    else if (nan_b_p1) sel_a = 1'b1;
    else if (zero_split) sel_a = (op_p1 == OP_MIN) ? sign_a : !sign_a;
    else if (op_p1 == OP_MIN) sel_a = !gt;
    else sel_a = gt || eq;

    res_c = 1'b0;
    val_c = a_p1;
    case (op_p1)
      OP_GT: res_c = gt;
      OP_GE: res_c = gt || eq;
      OP_LT: res_c = lt;
      OP_LE: res_c = lt || eq;
      OP_EQ: res_c = eq;
      OP_NE: res_c = !eq;
      OP_MIN, OP_MAX: begin
        if (nan_a_p1 && nan_b_p1) begin
          res_c = 1'b0;
          val_c = QNAN;
        end else begin
          res_c = sel_a;
          val_c = sel_a ? a_p1 : b_p1;
        end
      end
    endcase
  end

  // Stage 2: registered outputs, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      out_result    <= 1'b0;
      out_value     <= '0;
      out_unordered <= 1'b0;
      out_tag       <= '0;
    end else begin
      if (adv_p1) vld_p1 <= in_valid;
      if (adv_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          out_result    <= res_c;
          out_value     <= val_c;
          out_unordered <= unord;
          out_tag       <= tag_p1;
        end
      end
    end
  end
endmodule
